fb_double_buffer: RTL

Double-buffered RGB565 framebuffer serving the scan-out read port of the HDMI output path, and accepting pixel writes from the rasterizer into the hidden buffer. Reads always hit the front buffer and return one cycle after `rd_en`, matching the one-stage pipeline in the HDMI source selector. Swaps are requested by the rasterizer and committed only at a frame boundary, so scan-out never tears. After each swap the new back buffer is optionally cleared.

---
 rtl/celery_pkg.sv | 15 +
 rtl/video_pkg.sv | 19 +
 rtl/fb_bank_ram.sv | 37 +++
 rtl/fb_double_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/celery_pkg.sv
// celery_pkg -- shared pixel types for the video datapath.
// Revision 1.0
`default_nettype none

package celery_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

`default_nettype wire

// File: rtl/video_pkg.sv
// video_pkg -- framebuffer controller state encoding and address-width helper.
// Revision 1.0
`default_nettype none

package video_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SWAP = 2'd1,
        CLEAR     = 2'd2
    } fb_state_t;

    function automatic int fb_addr_w(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_bank_ram.sv
// fb_bank_ram -- one framebuffer bank: simple dual-port RAM, registered read port.
// Revision 1.0
`default_nettype none

module fb_bank_ram
    import celery_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  rgb565_t       wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output rgb565_t       rd_data_o
);

    rgb565_t mem_q [DEPTH];
    rgb565_t rd_data_q;

    // No reset on storage or read register so the bank maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/fb_double_buffer.sv
// fb_double_buffer -- tear-free double-buffered RGB565 framebuffer with post-swap clear.
// Revision 1.0
`default_nettype none

module fb_double_buffer
    import celery_pkg::*;
    import video_pkg::*;
#(
    parameter int      FB_WIDTH    = 64,
    parameter int      FB_HEIGHT   = 64,
    parameter rgb565_t CLEAR_COLOR = 16'h0000,
    parameter int      CLEAR_EN    = 1
) (
    input  logic                         pixel_clk,
    input  logic                         rst_n,
    input  logic [$clog2(FB_WIDTH)-1:0]  rd_x,
    input  logic [$clog2(FB_HEIGHT)-1:0] rd_y,
    input  logic                         rd_en,
    output rgb565_t                      rd_data,
    output logic                         rd_valid,
    input  logic [$clog2(FB_WIDTH)-1:0]  wr_x,
    input  logic [$clog2(FB_HEIGHT)-1:0] wr_y,
    input  rgb565_t                      wr_data,
    input  logic                         wr_en,
    output logic                         wr_ready,
    input  logic                         swap_req,
    input  logic                         frame_start,
    output logic                         front_sel,
    output logic                         swap_done,
    output logic                         busy
);

    localparam int            N         = FB_WIDTH * FB_HEIGHT;
    localparam int            XW        = $clog2(FB_WIDTH);
    localparam int            YW        = $clog2(FB_HEIGHT);
    localparam int            AW        = fb_addr_w(FB_WIDTH, FB_HEIGHT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [XW:0]   X_LIM     = (XW+1)'(FB_WIDTH);
    localparam logic [YW:0]   Y_LIM     = (YW+1)'(FB_HEIGHT);

    fb_state_t     state_q, state_d;
    logic          front_sel_q, front_sel_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          swap_done_q, swap_done_d;
    logic          wr_ready_q;
    logic          busy_q;
    logic          rd_valid_q;
    logic          rd_sel_q;
    logic          rd_zero_q;

    logic          rd_inb;
    logic          wr_inb;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          clearing;
    logic          wr_take;
    logic          do_write;
    logic [AW-1:0] bank_waddr;
    rgb565_t       bank_wdata;
    logic [1:0]    bank_we;
    logic [1:0]    bank_re;
    rgb565_t       bank_rd [2];

    assign rd_inb  = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
    assign wr_inb  = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
    assign rd_addr = AW'(rd_y) * AW'(FB_WIDTH) + AW'(rd_x);
    assign wr_addr = AW'(wr_y) * AW'(FB_WIDTH) + AW'(wr_x);

    // Out-of-range writes are consumed (wr_ready honoured) but never reach a bank.
    assign clearing   = (state_q == CLEAR);
    assign wr_take    = wr_en && wr_ready_q && wr_inb;
    assign do_write   = clearing || wr_take;
    assign bank_waddr = clearing ? clr_cnt_q : wr_addr;
    assign bank_wdata = clearing ? CLEAR_COLOR : wr_data;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = do_write && (front_sel_q != 1'(b));
        assign bank_re[b] = rd_en && rd_inb && (front_sel_q == 1'(b));

        fb_bank_ram #(
            .DEPTH (N),
            .AW    (AW)
        ) u_ram (
            .clk_i     (pixel_clk),
            .wr_en_i   (bank_we[b]),
            .wr_addr_i (bank_waddr),
            .wr_data_i (bank_wdata),
            .rd_en_i   (bank_re[b]),
            .rd_addr_i (rd_addr),
            .rd_data_o (bank_rd[b])
        );
    end

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        clr_cnt_d   = clr_cnt_q;
        swap_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    front_sel_d = !front_sel_q;
                    if (CLEAR_EN != 0) begin
                        state_d   = CLEAR;
                        clr_cnt_d = '0;
                    end else begin
                        state_d     = IDLE;
                        swap_done_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // swap_done is registered, so raise it for the cycle that will write the last address.
        if ((state_d == CLEAR) && (clr_cnt_d == LAST_ADDR)) begin
            swap_done_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            clr_cnt_q   <= '0;
            swap_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            clr_cnt_q   <= clr_cnt_d;
            swap_done_q <= swap_done_d;
            wr_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            rd_valid_q  <= rd_en;
            if (rd_en) begin
                rd_sel_q  <= front_sel_q;
                rd_zero_q <= !rd_inb;
            end
        end
    end

    // rd_zero_q resets high so rd_data reads 0 until the first in-range read returns.
    assign rd_data   = rd_zero_q ? rgb565_t'('0) : bank_rd[rd_sel_q];
    assign rd_valid  = rd_valid_q;
    assign wr_ready  = wr_ready_q;
    assign front_sel = front_sel_q;
    assign swap_done = swap_done_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire
